// File: rtl/fetch_queue.sv
// Instruction buffer between the I-cache read stage and decode: accepts up to two
// instructions per cycle and presents the two oldest queued entries in program order.
module fetch_queue #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_flush,
    input  logic [1:0][31:0]             i_in_instr,
    input  logic [1:0][ADDR_WIDTH-1:0]   i_in_addr,
    input  logic [1:0]                   i_in_valid,
    output logic                         o_in_ready,
    output logic [1:0][31:0]             o_out_instr,
    output logic [1:0][ADDR_WIDTH-1:0]   o_out_addr,
    output logic [1:0]                   o_out_valid,
    input  logic [1:0]                   i_deq_count,
    output logic [$clog2(DEPTH):0]       o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] EMPTY_INSTR = 32'h23;

    logic [31:0]           r_instrMem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_addrMem  [DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;

    logic                  w_inReady;
    logic                  w_doEnq;
    logic [CW-1:0]         w_nIn;
    logic [CW-1:0]         w_nOut;
    logic [CW-1:0]         w_deqReq;
    logic [PW-1:0]         w_slot1Idx;
    logic [PW-1:0]         w_headNext;

    // Ready depends only on registered occupancy, so a same-cycle dequeue never raises it.
    assign w_inReady  = (r_count <= CW'(DEPTH - 2));
    assign w_doEnq    = w_inReady && !i_flush;
    assign w_nIn      = w_inReady ? (CW'(i_in_valid[0]) + CW'(i_in_valid[1])) : '0;
    assign w_deqReq   = CW'(i_deq_count);
    assign w_nOut     = (w_deqReq < r_count) ? w_deqReq : r_count;
    // A lone valid slot 1 is compacted down into the tail entry.
    assign w_slot1Idx = i_in_valid[0] ? (r_tail + PW'(1)) : r_tail;
    assign w_headNext = r_head + PW'(1);

    always_ff @(posedge clk) begin
        if (w_doEnq) begin
            if (i_in_valid[0]) begin
                r_instrMem[r_tail] <= i_in_instr[0];
                r_addrMem[r_tail]  <= i_in_addr[0];
            end
            if (i_in_valid[1]) begin
                r_instrMem[w_slot1Idx] <= i_in_instr[1];
                r_addrMem[w_slot1Idx]  <= i_in_addr[1];
            end
        end
    end

    // Flush is treated exactly like reset and beats any enqueue or dequeue that cycle.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + w_nOut[PW-1:0];
            r_tail  <= r_tail + w_nIn[PW-1:0];
            r_count <= r_count + w_nIn - w_nOut;
        end
    end

    assign o_in_ready     = w_inReady;
    assign o_count        = r_count;
    assign o_out_valid[0] = (r_count >= CW'(1));
    assign o_out_valid[1] = (r_count >= CW'(2));
    assign o_out_instr[0] = o_out_valid[0] ? r_instrMem[r_head]     : EMPTY_INSTR;
    assign o_out_addr[0]  = o_out_valid[0] ? r_addrMem[r_head]      : '0;
    assign o_out_instr[1] = o_out_valid[1] ? r_instrMem[w_headNext] : EMPTY_INSTR;
    assign o_out_addr[1]  = o_out_valid[1] ? r_addrMem[w_headNext]  : '0;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the instruction cache read stage and decode. Each cycle it accepts up to two instruction/address pairs from the cache outputs and presents up to two of the oldest queued instructions to decode in program order. Its `in_ready` drives the cache stall input, so the cache holds its registered outputs until the queue can take them. Decode consumes a variable number of entries per cycle through `deq_count`.

## Interface
- `DEPTH`, 8: number of entries; power of two, at least 4.
- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  reset, synchronous, active-high; clock `clk`.
- `flush`  in  1  synchronous pipeline flush (branch redirect); empties queue.
- `in_instr[2]`  in  32 each  instruction words from the cache; slot 0 is older.
- `in_addr[2]`  in  `ADDR_WIDTH` each  fetch address of each slot.
- `in_valid[2]`  in  1 each  slot carries a real instruction.
- `in_ready`  out  1  queue accepts both slots this cycle; inverted, this is the cache stall.
- `out_instr[2]`  out  32 each  head and head+1 instructions; slot 0 is older.
- `out_addr[2]`  out  `ADDR_WIDTH` each  addresses of presented entries.
- `out_valid[2]`  out  1 each  presented entry is valid.
- `deq_count`  in  2  entries consumed by decode this cycle (0, 1 or 2).
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: circular buffer of DEPTH entries holding {instr, addr}. Head and tail pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. `count` is a registered value.
- `in_ready = (DEPTH - count) >= 2`. It uses only registered count. A same-cycle dequeue does not raise it.
- Enqueue occurs only when `in_ready` is high. Valid slots are written compacted and in order:
  - if both slots are valid, slot 0 goes to tail and slot 1 to tail+1;
  - if only one slot is valid, that slot goes to tail.
  - `n_in` = number of valid slots written. Tail advances by `n_in`.
- With `in_ready` low, inputs are ignored. The cache holds them under stall, so nothing is lost.
- Dequeue: `n_out = min(deq_count, count)`. A `deq_count` of 3 or a value above `count` is clamped to this. Head advances by `n_out`.
- `count_next = count + n_in - n_out`. This is always within 0..DEPTH.
- Outputs are combinational from registered state:
  - `out_valid[0] = count >= 1` and `out_valid[1] = count >= 2`.
  - `out_instr/out_addr[k]` read entry head+k modulo DEPTH.
  - A slot with `out_valid` low drives instr `32'h23` and addr 0.
- Flush and reset are identical. Head, tail and count become 0. Flush overrides any enqueue or dequeue in the same cycle; entries arriving that cycle are dropped.
- Reset values: `count`=0, `out_valid`=0/0, `out_instr`=`32'h23`/`32'h23`, `out_addr`=0/0, `in_ready`=1.

## Timing
- Enqueue-to-visible latency is 1 cycle. An entry written at edge N appears on `out_*` after edge N and can be dequeued in cycle N+1. There is no input-to-output bypass.
- Sustained throughput is 2 instructions per cycle when decode dequeues 2 per cycle and occupancy stays at most DEPTH-2.
- At `count` = DEPTH-1 or DEPTH, `in_ready` is low. It rises the cycle after dequeues bring `count` down to DEPTH-2 or lower.
- Wrap-around: writes and reads of two entries that straddle index DEPTH-1 to 0 must be seamless.
- Reset or flush asserted mid-stream takes effect at the next edge. `out_valid` is 0 in the following cycle.

## Test plan
- Reset, then idle. Expect `count`=0, `in_ready`=1 and `out_valid`=0/0 with `out_instr`=`32'h23`. Then push {A@0x0, B@0x4}: the next cycle shows `out_instr`={A,B} and `count`=2.
- Push `in_valid`={0,1} with C@0x8 into an empty queue. Expect C presented on slot 0, `out_valid`={1,0} and `count`=1. This covers compaction.
- Fill DEPTH=8 with 4 two-wide pushes and `deq_count`=0. Expect `in_ready`=0 and `count`=8, and a fifth push to be ignored. Then `deq_count`=2 for one cycle: `count`=6 and `in_ready`=1.
- Stream 20 sequential pushes of 2 with `deq_count`=2 every cycle. Expect in-order addresses 0x0, 0x4, … across pointer wrap, with `count` steady at 2.
- Hold `count`=5 and assert `flush` together with a valid push and `deq_count`=1. Expect `count`=0 and `out_valid`=0/0 the next cycle.
- Set `deq_count`=2 with `count`=1. Expect a clamped dequeue of 1 and `count`=0; no underflow and head equals tail.
